// File: rtl/lockin_demod_array.sv
// lockin_demod_array: shared-multiplier lock-in I/Q demodulator over NUM_CH channels with boxcar averaging (clk_i, reset_i, tick_i, data_i, sin_i, cos_i -> x_o, y_o, done_o, busy_o, overrun_o)
module lockin_demod_array #(
  parameter int NUM_CH    = 6,
  parameter int BITWIDTH  = 24,
  parameter int OUT_WIDTH = 32,
  parameter int LOG2_AVG  = 4
) (
  input  logic                          clk_i,
  input  logic                          reset_i,
  input  logic                          tick_i,
  input  logic [NUM_CH*BITWIDTH-1:0]    data_i,
  input  logic [BITWIDTH-1:0]           sin_i,
  input  logic [BITWIDTH-1:0]           cos_i,
  output logic [NUM_CH*OUT_WIDTH-1:0]   x_o,
  output logic [NUM_CH*OUT_WIDTH-1:0]   y_o,
  output logic                          done_o,
  output logic                          busy_o,
  output logic                          overrun_o
);
  localparam int NP = 2 * NUM_CH;
  localparam int PW = 2 * BITWIDTH;
  localparam int AW = PW + LOG2_AVG;
  localparam int SH = LOG2_AVG + PW - OUT_WIDTH;
  localparam int JW = $clog2(NP) + 1;
  localparam int CW = LOG2_AVG > 0 ? LOG2_AVG : 1;
  typedef enum logic [1:0] {IDLE, MUL, DRAIN} state_t;
  state_t state, state_nxt;
  logic [NUM_CH*BITWIDTH-1:0] sd;
  logic signed [BITWIDTH-1:0] ss, sc, opa, opb;
  logic [JW-1:0] j, pj;
  logic pv, last;
  logic signed [PW-1:0] prod;
  logic signed [AW-1:0] acc [NP];
  logic signed [AW-1:0] sum [NP];
  logic [CW-1:0] avg_cnt;
  always_ff @(posedge clk_i or posedge reset_i)
    if (reset_i) state <= IDLE;
    else state <= state_nxt;
  always_comb
    state_nxt = state == IDLE ? (tick_i ? MUL : IDLE) :
                state == MUL  ? (j == JW'(NP - 1) ? DRAIN : MUL) : IDLE;
  always_comb busy_o = state != IDLE;
  always_comb begin
    last = avg_cnt == CW'((1 << LOG2_AVG) - 1);
    opa = sd[(j >> 1) * BITWIDTH +: BITWIDTH];
    opb = j[0] ? sc : ss;
    for (int k = 0; k < NP; k++)
      sum[k] = acc[k] + ((pv && pj == JW'(k)) ? AW'(prod) : AW'(0));
  end
  always_ff @(posedge clk_i or posedge reset_i)
    if (reset_i) begin
      sd <= '0;
      ss <= '0;
      sc <= '0;
      j <= '0;
      pj <= '0;
      pv <= 1'b0;
      prod <= '0;
      avg_cnt <= '0;
      x_o <= '0;
      y_o <= '0;
      done_o <= 1'b0;
      overrun_o <= 1'b0;
      for (int k = 0; k < NP; k++) acc[k] <= '0;
    end else begin
      done_o <= state == DRAIN && last;
      pv <= state == MUL;
      pj <= j;
      prod <= PW'(opa) * PW'(opb);
      if (tick_i && state == IDLE) begin
        sd <= data_i;
        ss <= sin_i;
        sc <= cos_i;
        j <= '0;
      end
      if (tick_i && state != IDLE) overrun_o <= 1'b1;
      if (state == MUL) j <= j + JW'(1);
      if (state == DRAIN) avg_cnt <= last ? '0 : avg_cnt + CW'(1);
      for (int k = 0; k < NP; k++) acc[k] <= (state == DRAIN && last) ? '0 : sum[k];
      if (state == DRAIN && last)
        for (int c = 0; c < NUM_CH; c++) begin
          x_o[c*OUT_WIDTH +: OUT_WIDTH] <= OUT_WIDTH'(sum[2*c] >>> SH);
          y_o[c*OUT_WIDTH +: OUT_WIDTH] <= OUT_WIDTH'(sum[2*c+1] >>> SH);
        end
    end
endmodule

// File: tb/tb_lockin_demod_array.sv
// tb_lockin_demod_array: randomized self-checking bench for lockin_demod_array against an arithmetic I/Q averaging model
module tb_lockin_demod_array;
  localparam logic signed [23:0] P22 = 24'sh400000;
  localparam logic signed [23:0] N22 = 24'shC00000;
  localparam logic signed [23:0] N23 = 24'sh800000;
  logic clk_i, reset_i, tick_i;
  logic [47:0] data_i;
  logic [23:0] sin_i, cos_i;
  logic [63:0] x0, y0, x2, y2;
  logic done0, busy0, ovr0, done2, busy2, ovr2;
  longint sx0 [2], sy0 [2], sx2 [2], sy2 [2];
  logic [31:0] ex0 [2], ey0 [2], ex2 [2], ey2 [2];
  int cnt2, n_chk, n_err;
  bit ed0, ed2;
  lockin_demod_array #(.NUM_CH(2), .BITWIDTH(24), .OUT_WIDTH(32), .LOG2_AVG(0)) u0 (
    .clk_i(clk_i), .reset_i(reset_i), .tick_i(tick_i), .data_i(data_i), .sin_i(sin_i), .cos_i(cos_i),
    .x_o(x0), .y_o(y0), .done_o(done0), .busy_o(busy0), .overrun_o(ovr0));
  lockin_demod_array #(.NUM_CH(2), .BITWIDTH(24), .OUT_WIDTH(32), .LOG2_AVG(2)) u2 (
    .clk_i(clk_i), .reset_i(reset_i), .tick_i(tick_i), .data_i(data_i), .sin_i(sin_i), .cos_i(cos_i),
    .x_o(x2), .y_o(y2), .done_o(done2), .busy_o(busy2), .overrun_o(ovr2));
  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask
  function automatic logic signed [23:0] rnd();
    return 24'($urandom);
  endfunction
  task automatic model_clear();
    for (int k = 0; k < 2; k++) begin
      sx0[k] = 0; sy0[k] = 0; sx2[k] = 0; sy2[k] = 0;
      ex0[k] = 0; ey0[k] = 0; ex2[k] = 0; ey2[k] = 0;
    end
    cnt2 = 0;
    ed0 = 0;
    ed2 = 0;
  endtask
  task automatic model_tick(input logic signed [23:0] d0, d1, s, c);
    logic signed [23:0] d [2];
    d[0] = d0;
    d[1] = d1;
    for (int k = 0; k < 2; k++) begin
      sx0[k] += longint'(d[k]) * longint'(s);
      sy0[k] += longint'(d[k]) * longint'(c);
      sx2[k] += longint'(d[k]) * longint'(s);
      sy2[k] += longint'(d[k]) * longint'(c);
      ex0[k] = 32'(sx0[k] >>> 16);
      ey0[k] = 32'(sy0[k] >>> 16);
      sx0[k] = 0;
      sy0[k] = 0;
    end
    ed0 = 1;
    cnt2++;
    ed2 = cnt2 == 4;
    if (ed2) begin
      for (int k = 0; k < 2; k++) begin
        ex2[k] = 32'(sx2[k] >>> 18);
        ey2[k] = 32'(sy2[k] >>> 18);
        sx2[k] = 0;
        sy2[k] = 0;
      end
      cnt2 = 0;
    end
  endtask
  task automatic chk_outs();
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("u0.x%0d", k), 64'(x0[k*32 +: 32]), 64'(ex0[k]));
      chk($sformatf("u0.y%0d", k), 64'(y0[k*32 +: 32]), 64'(ey0[k]));
      chk($sformatf("u2.x%0d", k), 64'(x2[k*32 +: 32]), 64'(ex2[k]));
      chk($sformatf("u2.y%0d", k), 64'(y2[k*32 +: 32]), 64'(ey2[k]));
    end
  endtask
  task automatic tick_run(input logic signed [23:0] d0, d1, s, c, input int junk_at, input int rst_at);
    bit killed;
    killed = 0;
    data_i = {d1, d0};
    sin_i = s;
    cos_i = c;
    tick_i = 1'b1;
    model_tick(d0, d1, s, c);
    for (int i = 1; i <= 6; i++) begin
      @(posedge clk_i);
      #1;
      if (i == 1) begin
        tick_i = 1'b0;
        chk("busy", 64'({busy0, busy2}), 64'(2'b11));
      end
      if (i == junk_at) begin
        tick_i = 1'b1;
        data_i = 48'({$urandom, $urandom});
        sin_i = rnd();
        cos_i = rnd();
      end else if (i == junk_at + 1) tick_i = 1'b0;
      if (i == rst_at) begin
        reset_i = 1'b1;
        #1;
        model_clear();
        killed = 1;
        chk_outs();
        chk("rst_flags", 64'({done0, busy0, ovr0, done2, busy2, ovr2}), 64'(0));
      end
      if (i == rst_at + 1) reset_i = 1'b0;
      chk($sformatf("done0@%0d", i), 64'(done0), 64'(i == 6 && !killed && ed0));
      chk($sformatf("done2@%0d", i), 64'(done2), 64'(i == 6 && !killed && ed2));
    end
    chk("busy_end", 64'({busy0, busy2}), 64'(0));
    chk_outs();
  endtask
  task automatic do_reset();
    reset_i = 1'b1;
    @(posedge clk_i);
    #1;
    reset_i = 1'b0;
    model_clear();
    @(posedge clk_i);
    #1;
  endtask
  initial begin
    n_chk = 0;
    n_err = 0;
    reset_i = 1'b1;
    tick_i = 1'b0;
    data_i = '0;
    sin_i = '0;
    cos_i = '0;
    model_clear();
    repeat (3) @(posedge clk_i);
    #1;
    chk_outs();
    chk("reset_flags", 64'({done0, busy0, ovr0, done2, busy2, ovr2}), 64'(0));
    reset_i = 1'b0;
    @(posedge clk_i);
    #1;
    tick_run(P22, N22, P22, 24'sd0, 0, 0);
    chk("t1_x0", 64'(x0[31:0]), 64'(32'd268435456));
    chk("t1_x1", 64'(x0[63:32]), 64'(32'hF000_0000));
    chk("t1_y", 64'(y0), 64'(0));
    do_reset();
    tick_run(P22, 24'sd0, P22, 24'sd0, 0, 0);
    tick_run(N22, 24'sd0, P22, 24'sd0, 0, 0);
    tick_run(P22, 24'sd0, P22, 24'sd0, 0, 0);
    tick_run(P22, 24'sd0, P22, 24'sd0, 0, 0);
    chk("avg4_x0", 64'(x2[31:0]), 64'(32'd134217728));
    repeat (4) tick_run(24'sd0, 24'sd0, P22, 24'sd0, 0, 0);
    chk("avg4_clear", 64'(x2[31:0]), 64'(0));
    tick_run(N23, 24'sd0, N23, N23, 0, 0);
    chk("ext_x0", 64'(x0[31:0]), 64'(32'd1073741824));
    chk("ext_y0", 64'(y0[31:0]), 64'(32'd1073741824));
    tick_run(rnd(), rnd(), rnd(), rnd(), 3, 0);
    chk("ovr_set", 64'({ovr0, ovr2}), 64'(2'b11));
    tick_run(rnd(), rnd(), rnd(), rnd(), 0, 0);
    chk("ovr_sticky", 64'({ovr0, ovr2}), 64'(2'b11));
    tick_run(rnd(), rnd(), rnd(), rnd(), 0, 3);
    chk("ovr_clr", 64'({ovr0, ovr2}), 64'(0));
    tick_run(rnd(), rnd(), rnd(), rnd(), 0, 0);
    repeat (100) tick_run(rnd(), rnd(), rnd(), rnd(), 0, 0);
    chk("ovr_b2b", 64'({ovr0, ovr2}), 64'(0));
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
